// File: rtl/vga_scanout.sv
// VGA scanout stage: 640x480@60 raster counters, multiplier-free framebuffer address
// generation with 2^SCALE_SHIFT replication, and sync/colour aligned to VRAM read latency.
module vga_scanout #(
  parameter int H_VIS       = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_VIS       = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int SCALE_SHIFT = 1,
  parameter int ADDR_W      = 17,
  parameter int RD_LATENCY  = 1
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] vram_addr,
  input  logic [11:0]       vram_rdata,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              frame_start
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FB_W    = H_VIS >> SCALE_SHIFT;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_L    = 10'(H_VIS);
  localparam logic [9:0] V_VIS_L    = 10'(V_VIS);
  localparam logic [9:0] HS_START   = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [9:0] SCALE_MASK = 10'((1 << SCALE_SHIFT) - 1);
  localparam logic [ADDR_W-1:0] FB_W_L = ADDR_W'(FB_W);

  logic [9:0]            h_cnt_r;
  logic [9:0]            v_cnt_r;
  logic [ADDR_W-1:0]     line_base_r;
  logic [RD_LATENCY-1:0] de_pipe_r;
  logic [RD_LATENCY-1:0] hs_pipe_r;
  logic [RD_LATENCY-1:0] vs_pipe_r;
  logic [11:0]           rgb_r;
  logic                  hs_r;
  logic                  vs_r;
  logic                  frame_start_r;

  logic h_wrap_s;
  logic v_wrap_s;
  logic de_s;
  logic hs_s;
  logic vs_s;
  logic base_step_s;

  // Raster decode from the registered counters
  always_comb begin
    h_wrap_s    = (h_cnt_r == H_LAST);
    v_wrap_s    = (v_cnt_r == V_LAST);
    de_s        = (h_cnt_r < H_VIS_L) && (v_cnt_r < V_VIS_L);
    hs_s        = (h_cnt_r >= HS_START) && (h_cnt_r < HS_END);
    vs_s        = (v_cnt_r >= VS_START) && (v_cnt_r < VS_END);
    base_step_s = (v_cnt_r < V_VIS_L) && ((v_cnt_r & SCALE_MASK) == SCALE_MASK);
  end

  // Read address; zero outside the visible window
  always_comb begin
    if (de_s) begin
      vram_addr = line_base_r + ADDR_W'(h_cnt_r >> SCALE_SHIFT);
    end else begin
      vram_addr = {ADDR_W{1'b0}};
    end
  end

  // Horizontal/vertical counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt_r <= 10'd0;
      v_cnt_r <= 10'd0;
    end else if (h_wrap_s) begin
      h_cnt_r <= 10'd0;
      v_cnt_r <= v_wrap_s ? 10'd0 : v_cnt_r + 10'd1;
    end else begin
      h_cnt_r <= h_cnt_r + 10'd1;
    end
  end

  // Line base advances after the last replicated copy of a source row; frame wrap wins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_base_r <= {ADDR_W{1'b0}};
    end else if (h_wrap_s && v_wrap_s) begin
      line_base_r <= {ADDR_W{1'b0}};
    end else if (h_wrap_s && base_step_s) begin
      line_base_r <= line_base_r + FB_W_L;
    end
  end

  // Delay de/hs/vs to match the VRAM read latency
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      de_pipe_r <= {RD_LATENCY{1'b0}};
      hs_pipe_r <= {RD_LATENCY{1'b0}};
      vs_pipe_r <= {RD_LATENCY{1'b0}};
    end else begin
      de_pipe_r[0] <= de_s;
      hs_pipe_r[0] <= hs_s;
      vs_pipe_r[0] <= vs_s;
      for (int i = 1; i < RD_LATENCY; i++) begin
        de_pipe_r[i] <= de_pipe_r[i-1];
        hs_pipe_r[i] <= hs_pipe_r[i-1];
        vs_pipe_r[i] <= vs_pipe_r[i-1];
      end
    end
  end

  // Output register: colour gated by delayed de, active-low syncs, frame_start at (0,0)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_r         <= 12'h000;
      hs_r          <= 1'b1;
      vs_r          <= 1'b1;
      frame_start_r <= 1'b0;
    end else begin
      rgb_r         <= de_pipe_r[RD_LATENCY-1] ? vram_rdata : 12'h000;
      hs_r          <= ~hs_pipe_r[RD_LATENCY-1];
      vs_r          <= ~vs_pipe_r[RD_LATENCY-1];
      frame_start_r <= h_wrap_s && v_wrap_s;
    end
  end

  assign vga_r       = rgb_r[11:8];
  assign vga_g       = rgb_r[7:4];
  assign vga_b       = rgb_r[3:0];
  assign vga_hs      = hs_r;
  assign vga_vs      = vs_r;
  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout: default, 3-cycle latency, native and small-raster instances.
module tb_vga_scanout;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic fff_mode = 1'b1;
  always #20 clk = ~clk;

  int total = 0;
  int bad = 0;
  int n = 0;

  logic [16:0] d_addr, l_addr, s_addr;
  logic [18:0] nat_addr;
  logic [11:0] d_rdata, l_rdata, nat_rdata, s_rdata;
  logic        d_hs, d_vs, d_fs, l_hs, l_vs, l_fs, nat_hs, nat_vs, nat_fs, s_hs, s_vs, s_fs;
  logic [3:0]  d_r, d_g, d_b, l_r, l_g, l_b, nat_r, nat_g, nat_b, s_r, s_g, s_b;
  logic [11:0] l_pipe [3];

  // VRAM models: constant colour, data = address with 3-cycle latency, data = address with 1-cycle latency
  always_ff @(posedge clk) d_rdata <= fff_mode ? 12'hFFF : 12'hABC;
  always_ff @(posedge clk) begin
    l_pipe[0] <= l_addr[11:0];
    l_pipe[1] <= l_pipe[0];
    l_pipe[2] <= l_pipe[1];
  end
  assign l_rdata = l_pipe[2];
  always_ff @(posedge clk) nat_rdata <= nat_addr[11:0];
  assign s_rdata = 12'hABC;

  vga_scanout u_def (
    .clk(clk), .reset(reset), .vram_addr(d_addr), .vram_rdata(d_rdata),
    .vga_hs(d_hs), .vga_vs(d_vs), .vga_r(d_r), .vga_g(d_g), .vga_b(d_b), .frame_start(d_fs));

  vga_scanout #(.RD_LATENCY(3)) u_lat3 (
    .clk(clk), .reset(reset), .vram_addr(l_addr), .vram_rdata(l_rdata),
    .vga_hs(l_hs), .vga_vs(l_vs), .vga_r(l_r), .vga_g(l_g), .vga_b(l_b), .frame_start(l_fs));

  vga_scanout #(.SCALE_SHIFT(0), .ADDR_W(19)) u_nat (
    .clk(clk), .reset(reset), .vram_addr(nat_addr), .vram_rdata(nat_rdata),
    .vga_hs(nat_hs), .vga_vs(nat_vs), .vga_r(nat_r), .vga_g(nat_g), .vga_b(nat_b), .frame_start(nat_fs));

  vga_scanout #(.H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
                .V_VIS(8), .V_FP(1), .V_SYNC(2), .V_BP(1)) u_sml (
    .clk(clk), .reset(reset), .vram_addr(s_addr), .vram_rdata(s_rdata),
    .vga_hs(s_hs), .vga_vs(s_vs), .vga_r(s_r), .vga_g(s_g), .vga_b(s_b), .frame_start(s_fs));

  typedef struct {
    int sel;
    int cyc;
    int addr;
    int rgb;
    int hs;
    int vs;
    int fs;
  } vec_t;

  typedef struct {
    int prev;
    int falls;
    int first;
    int last;
    int gap_bad;
    int run;
    int len_bad;
  } trk_t;

  vec_t tbl[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    n++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    #1;
  endtask

  task automatic add(input int sel, input int cyc, input int addr, input int rgb, input int hs);
    tbl.push_back('{sel, cyc, addr, rgb, hs, 1, 0});
  endtask

  task automatic get(input int sel, output int a, output int r, output int h, output int v, output int f);
    case (sel)
      0:       begin a = int'(d_addr);   r = int'({d_r, d_g, d_b});       h = int'(d_hs);   v = int'(d_vs);   f = int'(d_fs);   end
      1:       begin a = int'(l_addr);   r = int'({l_r, l_g, l_b});       h = int'(l_hs);   v = int'(l_vs);   f = int'(l_fs);   end
      2:       begin a = int'(nat_addr); r = int'({nat_r, nat_g, nat_b}); h = int'(nat_hs); v = int'(nat_vs); f = int'(nat_fs); end
      default: begin a = int'(s_addr);   r = int'({s_r, s_g, s_b});       h = int'(s_hs);   v = int'(s_vs);   f = int'(s_fs);   end
    endcase
  endtask

  // Edge tracker for an active-low strobe: checks fall spacing and low length
  task automatic trk(inout trk_t t, input logic sig, input int per, input int len);
    if (!sig) begin
      if (t.prev != 0) begin
        t.falls++;
        if (t.first < 0) t.first = n;
        else if (n - t.last != per) t.gap_bad++;
        t.last = n;
      end
      t.run++;
    end else begin
      if (t.prev == 0 && t.run != len) t.len_bad++;
      t.run = 0;
    end
    t.prev = int'(sig);
  endtask

  initial begin : main
    int a, r, h, v, f;
    trk_t hs_t, vs_t;
    int fs_cnt, fs_first, fs_last, fs_gap_bad, rgb_cnt, rgb_bad, max_addr;

    // sel 0: default (ABC), sel 1: latency 3 (data=addr), sel 2: native (data=addr)
    add(0, 0, 0, 0, 1);          add(0, 1, 0, 0, 1);
    add(0, 2, 1, 'hABC, 1);      add(2, 2, 2, 0, 1);
    add(0, 3, 1, 'hABC, 1);      add(1, 3, 1, 0, 1);
    add(1, 4, 2, 0, 1);          add(2, 5, 5, 3, 1);
    add(1, 6, 3, 1, 1);          add(1, 7, 3, 1, 1);
    add(1, 100, 50, 48, 1);      add(0, 639, 319, 'hABC, 1);
    add(0, 640, 0, 'hABC, 1);    add(0, 641, 0, 'hABC, 1);
    add(2, 641, 0, 639, 1);      add(0, 642, 0, 0, 1);
    add(1, 643, 0, 319, 1);      add(1, 644, 0, 0, 1);
    add(0, 657, 0, 0, 1);        add(0, 658, 0, 0, 0);
    add(1, 659, 0, 0, 1);        add(1, 660, 0, 0, 0);
    add(0, 700, 0, 0, 0);        add(0, 753, 0, 0, 0);
    add(0, 754, 0, 0, 1);        add(1, 755, 0, 0, 0);
    add(1, 756, 0, 0, 1);        add(0, 800, 0, 0, 1);
    add(2, 800, 640, 0, 1);      add(0, 802, 1, 'hABC, 1);
    add(0, 1439, 319, 'hABC, 1); add(0, 1600, 320, 0, 1);
    add(2, 1600, 1280, 0, 1);    add(0, 1601, 320, 0, 1);
    add(0, 1602, 321, 'hABC, 1); add(2, 1602, 1282, 1280, 1);
    add(1, 1604, 322, 320, 1);   add(1, 1606, 323, 321, 1);
    add(2, 1639, 1319, 1317, 1); add(0, 2400, 320, 0, 1);
    add(2, 2400, 1920, 0, 1);    add(0, 3200, 640, 0, 1);

    // Asynchronous reset mid-line while colour is being driven
    do_reset();
    while (n < 20) step();
    get(0, a, r, h, v, f);
    check("pre_rst_rgb", r, 'hFFF);
    check("pre_rst_addr", a, 10);
    #3 reset = 1'b1;
    #1 get(0, a, r, h, v, f);
    check("rst_addr", a, 0);
    check("rst_rgb", r, 0);
    check("rst_hs", h, 1);
    check("rst_vs", v, 1);
    check("rst_fs", f, 0);

    // Asynchronous reset while HS is low
    do_reset();
    while (n < 700) step();
    get(0, a, r, h, v, f);
    check("pre_rst2_hs", h, 0);
    #3 reset = 1'b1;
    #1 get(0, a, r, h, v, f);
    check("rst2_hs", h, 1);

    // Table of directed vectors
    fff_mode = 1'b0;
    do_reset();
    foreach (tbl[i]) begin
      while (n < tbl[i].cyc) step();
      get(tbl[i].sel, a, r, h, v, f);
      check($sformatf("v%0d_c%0d_addr", i, tbl[i].cyc), a, tbl[i].addr);
      check($sformatf("v%0d_c%0d_rgb", i, tbl[i].cyc), r, tbl[i].rgb);
      check($sformatf("v%0d_c%0d_hs", i, tbl[i].cyc), h, tbl[i].hs);
      check($sformatf("v%0d_c%0d_vs", i, tbl[i].cyc), v, tbl[i].vs);
      check($sformatf("v%0d_c%0d_fs", i, tbl[i].cyc), f, tbl[i].fs);
    end

    // Small raster (24x12, frame 288): three frames of periods, wrap and address range
    hs_t = '{1, 0, -1, -1, 0, 0, 0};
    vs_t = '{1, 0, -1, -1, 0, 0, 0};
    fs_cnt = 0; fs_first = -1; fs_last = -1; fs_gap_bad = 0;
    rgb_cnt = 0; rgb_bad = 0; max_addr = 0;
    do_reset();
    while (n < 864) begin
      get(3, a, r, h, v, f);
      if (f != 0) begin
        if (fs_last >= 0 && n - fs_last != 288) fs_gap_bad++;
        if (fs_first < 0) fs_first = n;
        fs_last = n;
        fs_cnt++;
      end
      trk(hs_t, s_hs, 24, 4);
      trk(vs_t, s_vs, 288, 48);
      if (n >= 2 && n < 290 && r != 0) rgb_cnt++;
      if (r != 0 && r != 'hABC) rgb_bad++;
      if (n < 288 && a > max_addr) max_addr = a;
      if (n == 48)  check("sml_line2_addr", a, 8);
      if (n == 183) check("sml_last_vis_addr", a, 31);
      if (n == 288) check("sml_wrap_addr", a, 0);
      if (n == 336) check("sml_f2_line2_addr", a, 8);
      step();
    end
    check("fs_count", fs_cnt, 2);
    check("fs_first", fs_first, 288);
    check("fs_gap", fs_gap_bad, 0);
    check("hs_first_fall", hs_t.first, 20);
    check("hs_falls", hs_t.falls, 36);
    check("hs_gap", hs_t.gap_bad, 0);
    check("hs_low_len", hs_t.len_bad, 0);
    check("vs_first_fall", vs_t.first, 218);
    check("vs_falls", vs_t.falls, 3);
    check("vs_gap", vs_t.gap_bad, 0);
    check("vs_low_len", vs_t.len_bad, 0);
    check("rgb_visible_count", rgb_cnt, 128);
    check("rgb_value", rgb_bad, 0);
    check("max_addr", max_addr, 31);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
